dram_axi_responder: RTL and testbench

- Synthesizable AXI-lite-style responder, the DRAM end of the bridge's AR/R/AW/W/B channels.
- Stores 256 × 64-bit words at a 17-bit byte address window. Handles one transaction at a time, with programmable read latency.
- Replaces the behavioural DRAM model so the BEV + bridge + memory path can be simulated and synthesized as RTL.

---
 rtl/dram_axi_responder.sv | 226 ++++++++++++++++++++++
 tb/tb_dram_axi_responder.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_axi_responder.sv
// ============================================================================
// dram_axi_responder
//
// Purpose:
//   DRAM end of the bridge's AXI-lite-style AR/R/AW/W/B channels. This is a
//   synthesizable stand-in for the old behavioural DRAM model. It holds DEPTH
//   64-bit words starting at byte address BASE_ADDR and serves one
//   transaction at a time. Reads return data RD_LAT cycles after the AR
//   handshake. Writes take AW first, then one W beat, then answer on B.
//
// Parameters:
//   BASE_ADDR  byte address of word 0
//   DEPTH      number of 64-bit words (power of 2)
//   RD_LAT     cycles from AR handshake to R_VALID rise (1..15)
//
// Ports:
//   clk, rst                         clock (rising edge), async active-high reset
//   AR_VALID/AR_ADDR/AR_READY        read address channel
//   R_VALID/R_DATA/R_RESP/R_READY    read data channel (RESP 00 OKAY, 10 SLVERR)
//   AW_VALID/AW_ADDR/AW_READY        write address channel
//   W_VALID/W_DATA/W_READY           write data channel
//   B_VALID/B_RESP/B_READY           write response channel
//
// Configuration macro:
//   DRAM_ADDR_CHECK_EN  when defined, a misaligned or out-of-window access is
//                       rejected with SLVERR. A rejected read returns zero data
//                       and a rejected write leaves memory untouched. When the
//                       macro is undefined, the word index simply wraps by
//                       truncation and every response is OKAY.
//
// The memory array is deliberately not reset, so its contents survive rst.
// ============================================================================
module dram_axi_responder #(
    parameter logic [16:0] BASE_ADDR = 17'h10000,
    parameter int          DEPTH     = 256,
    parameter int          RD_LAT    = 2
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        AR_VALID,
    input  logic [16:0] AR_ADDR,
    output logic        AR_READY,

    output logic        R_VALID,
    output logic [63:0] R_DATA,
    output logic [1:0]  R_RESP,
    input  logic        R_READY,

    input  logic        AW_VALID,
    input  logic [16:0] AW_ADDR,
    output logic        AW_READY,

    input  logic        W_VALID,
    input  logic [63:0] W_DATA,
    output logic        W_READY,

    output logic        B_VALID,
    output logic [1:0]  B_RESP,
    input  logic        B_READY
);

    localparam int          IDX_W    = $clog2(DEPTH);
    localparam logic [31:0] BASE_32  = {15'd0, BASE_ADDR};
    localparam logic [31:0] LIMIT_32 = BASE_32 + 32'(8 * DEPTH);
    localparam logic [3:0]  LAT_INIT = 4'(RD_LAT - 1);

`ifdef DRAM_ADDR_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_RESP,
        WR_DATA,
        WR_RESP
    } state_t;

    state_t             state;
    logic [3:0]         lat_cnt;
    logic [16:0]        rd_addr;
    logic [16:0]        wr_addr;
    logic [63:0]        mem [DEPTH];

    logic [16:0]        rd_src;
    logic [IDX_W-1:0]   rd_idx;
    logic [IDX_W-1:0]   wr_idx;
    logic               rd_ok;
    logic               wr_ok;
    logic [63:0]        rd_word;
    logic [1:0]         rd_resp_val;

    // Word index relative to the window base. The upper bits are dropped,
    // so an unchecked access wraps around the array.
    function automatic logic [IDX_W-1:0] word_index(input logic [16:0] addr);
        logic [16:0] offset;
        offset = addr - BASE_ADDR;
        return IDX_W'(offset >> 3);
    endfunction

    // An address is legal only if it is word aligned and lies inside the window.
    function automatic logic addr_legal(input logic [16:0] addr);
        logic [31:0] a32;
        a32 = {15'd0, addr};
        return (a32 >= BASE_32) && (a32 < LIMIT_32) && (addr[2:0] == 3'd0);
    endfunction

    // AW is only offered while idle, and a concurrent AR request takes priority over it.
    assign AW_READY = AR_READY && !AR_VALID;

    // With RD_LAT=1 the read data is loaded on the AR handshake edge itself,
    // before rd_addr has been captured. The lookup therefore uses the live
    // AR_ADDR while idle and the latched rd_addr afterwards.
    always_comb begin
        rd_src      = (state == IDLE) ? AR_ADDR : rd_addr;
        rd_idx      = word_index(rd_src);
        wr_idx      = word_index(wr_addr);
        rd_ok       = CHECK_EN ? addr_legal(rd_src) : 1'b1;
        wr_ok       = CHECK_EN ? addr_legal(wr_addr) : 1'b1;
        rd_word     = rd_ok ? mem[rd_idx] : 64'd0;
        rd_resp_val = rd_ok ? RESP_OKAY : RESP_SLVERR;
    end

    // Storage write port. It has no reset, so the array keeps its contents
    // across rst. W_READY is cleared asynchronously by rst, so a write that
    // is still waiting for its W beat cannot land.
    always_ff @(posedge clk) begin
        if (W_READY && W_VALID && wr_ok) begin
            mem[wr_idx] <= W_DATA;
        end
    end

    // Transaction sequencer. All handshake outputs are registered here.
    // AR_READY doubles as the "idle and ready" flag, so it reads 0 during the
    // first idle cycle after reset and rises on the first clock edge after that.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            lat_cnt  <= 4'd0;
            rd_addr  <= 17'd0;
            wr_addr  <= 17'd0;
            AR_READY <= 1'b0;
            W_READY  <= 1'b0;
            R_VALID  <= 1'b0;
            R_DATA   <= 64'd0;
            R_RESP   <= 2'b00;
            B_VALID  <= 1'b0;
            B_RESP   <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    AR_READY <= 1'b1;
                    if (AR_VALID && AR_READY) begin
                        rd_addr  <= AR_ADDR;
                        AR_READY <= 1'b0;
                        if (RD_LAT == 1) begin
                            R_DATA  <= rd_word;
                            R_RESP  <= rd_resp_val;
                            R_VALID <= 1'b1;
                            state   <= RD_RESP;
                        end else begin
                            lat_cnt <= LAT_INIT;
                            state   <= RD_WAIT;
                        end
                    end else if (AW_VALID && AW_READY) begin
                        wr_addr  <= AW_ADDR;
                        AR_READY <= 1'b0;
                        W_READY  <= 1'b1;
                        state    <= WR_DATA;
                    end
                end

                // The counter starts at RD_LAT-1. The load happens on the edge
                // where it would reach zero, which puts R_VALID exactly
                // RD_LAT cycles after the AR handshake.
                RD_WAIT: begin
                    if (lat_cnt <= 4'd1) begin
                        lat_cnt <= 4'd0;
                        R_DATA  <= rd_word;
                        R_RESP  <= rd_resp_val;
                        R_VALID <= 1'b1;
                        state   <= RD_RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end

                RD_RESP: begin
                    if (R_READY) begin
                        R_VALID  <= 1'b0;
                        AR_READY <= 1'b1;
                        state    <= IDLE;
                    end
                end

                WR_DATA: begin
                    if (W_VALID) begin
                        W_READY <= 1'b0;
                        B_VALID <= 1'b1;
                        B_RESP  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
                        state   <= WR_RESP;
                    end
                end

                WR_RESP: begin
                    if (B_READY) begin
                        B_VALID  <= 1'b0;
                        AR_READY <= 1'b1;
                        state    <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dram_axi_responder.sv
// ============================================================================
// tb_dram_axi_responder
//
// Directed bench for dram_axi_responder. Two instances run in lockstep on the
// same inputs: dut0 uses RD_LAT=2 and dut1 uses RD_LAT=1. dut1 holds its
// R_VALID until the shared R_READY, so both instances finish every
// transaction on the same edge. A vector table drives the plain write/read
// traffic. Hand-written sequences cover reset, AR/AW collision, R
// backpressure and reset during WR_DATA.
// ============================================================================
module tb_dram_axi_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        AR_VALID = 1'b0;
    logic [16:0] AR_ADDR = '0;
    logic        R_READY = 1'b0;
    logic        AW_VALID = 1'b0;
    logic [16:0] AW_ADDR = '0;
    logic        W_VALID = 1'b0;
    logic [63:0] W_DATA = '0;
    logic        B_READY = 1'b0;

    logic        AR_READY, R_VALID, AW_READY, W_READY, B_VALID;
    logic [63:0] R_DATA;
    logic [1:0]  R_RESP, B_RESP;

    logic        ar_ready1, r_valid1, aw_ready1, w_ready1, b_valid1;
    logic [63:0] r_data1;
    logic [1:0]  r_resp1, b_resp1;

    int compared   = 0;
    int mismatched = 0;

    dram_axi_responder #(.BASE_ADDR(17'h10000), .DEPTH(256), .RD_LAT(2)) dut0 (
        .clk(clk), .rst(rst),
        .AR_VALID(AR_VALID), .AR_ADDR(AR_ADDR), .AR_READY(AR_READY),
        .R_VALID(R_VALID), .R_DATA(R_DATA), .R_RESP(R_RESP), .R_READY(R_READY),
        .AW_VALID(AW_VALID), .AW_ADDR(AW_ADDR), .AW_READY(AW_READY),
        .W_VALID(W_VALID), .W_DATA(W_DATA), .W_READY(W_READY),
        .B_VALID(B_VALID), .B_RESP(B_RESP), .B_READY(B_READY)
    );

    dram_axi_responder #(.BASE_ADDR(17'h10000), .DEPTH(256), .RD_LAT(1)) dut1 (
        .clk(clk), .rst(rst),
        .AR_VALID(AR_VALID), .AR_ADDR(AR_ADDR), .AR_READY(ar_ready1),
        .R_VALID(r_valid1), .R_DATA(r_data1), .R_RESP(r_resp1), .R_READY(R_READY),
        .AW_VALID(AW_VALID), .AW_ADDR(AW_ADDR), .AW_READY(aw_ready1),
        .W_VALID(W_VALID), .W_DATA(W_DATA), .W_READY(w_ready1),
        .B_VALID(b_valid1), .B_RESP(b_resp1), .B_READY(B_READY)
    );

    always #5 clk = ~clk;

    // Hard stop in case a sequence wedges in a way the bounded waits do not catch.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        string       name;
        bit          is_wr;
        logic [16:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs[$];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        checkOutput(name, 64'(act), 64'(exp));
    endtask

    task automatic doWrite(input string name, input logic [16:0] addr,
                           input logic [63:0] data, input logic [1:0] exp_resp);
        int n;
        AW_ADDR  = addr;
        AW_VALID = 1'b1;
        #1;
        n = 0;
        while (!AW_READY && n < 20) begin
            @(posedge clk); #1; n++;
        end
        checkBit({name, "/aw_ready"}, AW_READY, 1'b1);
        @(posedge clk); #1;
        AW_VALID = 1'b0;
        checkBit({name, "/w_ready"}, W_READY, 1'b1);
        checkBit({name, "/w_ready1"}, w_ready1, 1'b1);
        W_DATA  = data;
        W_VALID = 1'b1;
        @(posedge clk); #1;
        W_VALID = 1'b0;
        checkBit({name, "/b_valid"}, B_VALID, 1'b1);
        checkOutput({name, "/b_resp"}, 64'(B_RESP), 64'(exp_resp));
        checkOutput({name, "/b_resp1"}, 64'(b_resp1), 64'(exp_resp));
        B_READY = 1'b1;
        @(posedge clk); #1;
        B_READY = 1'b0;
        checkBit({name, "/ar_ready_after_b"}, AR_READY, 1'b1);
    endtask

    task automatic doRead(input string name, input logic [16:0] addr,
                          input logic [63:0] exp_data, input logic [1:0] exp_resp);
        int n;
        int cycles;
        int lat1;
        AR_ADDR  = addr;
        AR_VALID = 1'b1;
        #1;
        n = 0;
        while (!AR_READY && n < 20) begin
            @(posedge clk); #1; n++;
        end
        checkBit({name, "/ar_ready"}, AR_READY, 1'b1);
        @(posedge clk); #1;
        AR_VALID = 1'b0;
        cycles = 1;
        lat1   = 0;
        forever begin
            if (r_valid1 && lat1 == 0) lat1 = cycles;
            if (R_VALID || cycles >= 20) break;
            @(posedge clk); #1;
            cycles++;
        end
        checkBit({name, "/r_valid"}, R_VALID, 1'b1);
        checkOutput({name, "/lat_rdlat2"}, 64'(cycles), 64'd2);
        checkOutput({name, "/lat_rdlat1"}, 64'(lat1), 64'd1);
        checkOutput({name, "/r_data"}, R_DATA, exp_data);
        checkOutput({name, "/r_resp"}, 64'(R_RESP), 64'(exp_resp));
        checkOutput({name, "/r_data1"}, r_data1, exp_data);
        checkOutput({name, "/r_resp1"}, 64'(r_resp1), 64'(exp_resp));
        R_READY = 1'b1;
        @(posedge clk); #1;
        R_READY = 1'b0;
        checkBit({name, "/ar_ready_after_r"}, AR_READY, 1'b1);
    endtask

    task automatic applyStimulus(input vec_t v);
        if (v.is_wr) doWrite(v.name, v.addr, v.wdata, v.exp_resp);
        else         doRead(v.name, v.addr, v.exp_data, v.exp_resp);
    endtask

    localparam logic [63:0] PAT_A  = 64'hDEAD_BEEF_0123_4567;
    localparam logic [63:0] PAT_W0 = 64'h1111_2222_3333_4444;
    localparam logic [63:0] PAT_LS = 64'hA5A5_5A5A_C3C3_3C3C;
    localparam logic [63:0] PAT_WR = 64'h7777_8888_9999_AAAA;
    localparam logic [63:0] PAT_10 = 64'h0BAD_F00D_CAFE_0010;

    initial begin
        logic [63:0] word0_exp;
        int n;

        // ---------------- reset values ----------------
        repeat (3) @(posedge clk);
        #1;
        checkBit("rst/ar_ready", AR_READY, 1'b0);
        checkBit("rst/aw_ready", AW_READY, 1'b0);
        checkBit("rst/w_ready", W_READY, 1'b0);
        checkBit("rst/r_valid", R_VALID, 1'b0);
        checkBit("rst/b_valid", B_VALID, 1'b0);
        checkOutput("rst/r_data", R_DATA, 64'd0);
        checkOutput("rst/r_resp", 64'(R_RESP), 64'd0);
        checkOutput("rst/b_resp", 64'(B_RESP), 64'd0);
        checkBit("rst/ar_ready1", ar_ready1, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;
        checkBit("post_rst/ar_ready", AR_READY, 1'b1);
        checkBit("post_rst/aw_ready", AW_READY, 1'b1);
        AR_VALID = 1'b1;
        #1;
        checkBit("post_rst/aw_ready_ar_wins", AW_READY, 1'b0);
        AR_VALID = 1'b0;
        #1;

        // ---------------- vector table ----------------
        vecs.push_back('{"wr_10008", 1'b1, 17'h10008, PAT_A,  64'd0,  2'b00});
        vecs.push_back('{"rd_10008", 1'b0, 17'h10008, 64'd0,  PAT_A,  2'b00});
        vecs.push_back('{"wr_10000", 1'b1, 17'h10000, PAT_W0, 64'd0,  2'b00});
        vecs.push_back('{"wr_last",  1'b1, 17'h107F8, PAT_LS, 64'd0,  2'b00});
        vecs.push_back('{"rd_last",  1'b0, 17'h107F8, 64'd0,  PAT_LS, 2'b00});
        vecs.push_back('{"rd_10000", 1'b0, 17'h10000, 64'd0,  PAT_W0, 2'b00});
`ifdef DRAM_ADDR_CHECK_EN
        vecs.push_back('{"wr_oor",    1'b1, 17'h10804, PAT_WR, 64'd0,  2'b10});
        vecs.push_back('{"rd_misal",  1'b0, 17'h10003, 64'd0,  64'd0,  2'b10});
        vecs.push_back('{"rd_w0_kept",1'b0, 17'h10000, 64'd0,  PAT_W0, 2'b00});
        vecs.push_back('{"rd_oor",    1'b0, 17'h10800, 64'd0,  64'd0,  2'b10});
        word0_exp = PAT_W0;
`else
        vecs.push_back('{"rd_misal",  1'b0, 17'h10003, 64'd0,  PAT_W0, 2'b00});
        vecs.push_back('{"wr_wrap",   1'b1, 17'h10804, PAT_WR, 64'd0,  2'b00});
        vecs.push_back('{"rd_w0_wrap",1'b0, 17'h10000, 64'd0,  PAT_WR, 2'b00});
        vecs.push_back('{"rd_wrap",   1'b0, 17'h10800, 64'd0,  PAT_WR, 2'b00});
        word0_exp = PAT_WR;
`endif
        foreach (vecs[i]) applyStimulus(vecs[i]);

        // ---------------- simultaneous AR + AW ----------------
        AR_ADDR  = 17'h10000;
        AW_ADDR  = 17'h10010;
        AR_VALID = 1'b1;
        AW_VALID = 1'b1;
        #1;
        checkBit("simul/ar_ready", AR_READY, 1'b1);
        checkBit("simul/aw_ready", AW_READY, 1'b0);
        @(posedge clk); #1;
        AR_VALID = 1'b0;
        checkBit("simul/aw_ready_busy", AW_READY, 1'b0);
        checkBit("simul/aw_ready1_busy", aw_ready1, 1'b0);
        n = 0;
        while (!R_VALID && n < 20) begin
            @(posedge clk); #1; n++;
        end
        checkBit("simul/r_valid", R_VALID, 1'b1);
        checkOutput("simul/r_data", R_DATA, word0_exp);
        checkBit("simul/no_w_ready", W_READY, 1'b0);
        R_READY = 1'b1;
        @(posedge clk); #1;
        R_READY = 1'b0;
        checkBit("simul/aw_ready_after_rd", AW_READY, 1'b1);
        @(posedge clk); #1;
        AW_VALID = 1'b0;
        checkBit("simul/w_ready", W_READY, 1'b1);
        W_DATA  = PAT_10;
        W_VALID = 1'b1;
        @(posedge clk); #1;
        W_VALID = 1'b0;
        checkBit("simul/b_valid", B_VALID, 1'b1);
        B_READY = 1'b1;
        @(posedge clk); #1;
        B_READY = 1'b0;
        doRead("simul/rd_10010", 17'h10010, PAT_10, 2'b00);

        // ---------------- R backpressure ----------------
        AR_ADDR  = 17'h10008;
        AR_VALID = 1'b1;
        #1;
        checkBit("bp/ar_ready", AR_READY, 1'b1);
        @(posedge clk); #1;
        AR_VALID = 1'b0;
        n = 0;
        while (!R_VALID && n < 20) begin
            @(posedge clk); #1; n++;
        end
        for (int c = 0; c < 5; c++) begin
            checkBit($sformatf("bp%0d/r_valid", c), R_VALID, 1'b1);
            checkOutput($sformatf("bp%0d/r_data", c), R_DATA, PAT_A);
            checkOutput($sformatf("bp%0d/r_resp", c), 64'(R_RESP), 64'd0);
            checkBit($sformatf("bp%0d/ar_ready", c), AR_READY, 1'b0);
            @(posedge clk); #1;
        end
        R_READY = 1'b1;
        @(posedge clk); #1;
        R_READY = 1'b0;
        checkBit("bp/r_valid_dropped", R_VALID, 1'b0);

        // ---------------- reset while in WR_DATA ----------------
        AW_ADDR  = 17'h10008;
        AW_VALID = 1'b1;
        #1;
        @(posedge clk); #1;
        AW_VALID = 1'b0;
        checkBit("rstwr/w_ready_before", W_READY, 1'b1);
        W_DATA  = 64'hFFFF_FFFF_FFFF_FFFF;
        W_VALID = 1'b1;
        rst     = 1'b1;
        #1;
        checkBit("rstwr/w_ready", W_READY, 1'b0);
        checkBit("rstwr/w_ready1", w_ready1, 1'b0);
        checkBit("rstwr/ar_ready", AR_READY, 1'b0);
        checkBit("rstwr/aw_ready", AW_READY, 1'b0);
        checkBit("rstwr/r_valid", R_VALID, 1'b0);
        checkBit("rstwr/b_valid", B_VALID, 1'b0);
        checkOutput("rstwr/r_data", R_DATA, 64'd0);
        checkOutput("rstwr/r_data1", r_data1, 64'd0);
        checkOutput("rstwr/b_resp", 64'(B_RESP), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        W_VALID = 1'b0;
        rst     = 1'b0;
        @(posedge clk); #1;
        checkBit("rstwr/ar_ready_release", AR_READY, 1'b1);
        doRead("rstwr/rd_10008", 17'h10008, PAT_A, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
